cpu7_csr_timer: RTL and testbench
=================================

# cpu7_csr_timer

Constant-timer and timer-interrupt source for the cpu7 core. Owns the timer CSRs TID (0x40), TCFG (0x41), TVAL (0x42) and TICLR (0x44), plus a 64-bit free-running stable counter. It sits beside and upstream of the main CSR block: it decodes the same CSR write bus, returns its own read data for the parent to OR into the CSR read path, and feeds the timer interrupt bit (ESTAT.IS[11]) and a gated interrupt request to the exception control logic.

## Interface
- `TVAL_W`, 32: countdown width; must satisfy 3 ≤ TVAL_W ≤ `GRLEN.
- `CORE_ID`, 0: reset value of TID.
- `clk`  in  1  core clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `csr_waddr`  in  `LSOC1K_CSR_BIT  CSR write address.
- `csr_wdata`  in  `GRLEN  CSR write data.
- `csr_wen`  in  1  CSR write strobe; a write commits at the edge where it is high.
- `csr_raddr`  in  `LSOC1K_CSR_BIT  CSR read address.
- `timer_rdata`  out  `GRLEN  read data; zero unless raddr hits TID, TCFG or TVAL.
- `crmd_ie`  in  1  global interrupt enable from CRMD.
- `timer_is`  out  1  timer interrupt pending, i.e. ESTAT.IS[11].
- `timer_int_req`  out  1  `timer_is & crmd_ie`, combinational.
- `stable_cnt`  out  64  free-running counter for rdcntvl/rdcntvh.

## Operation
- **TID**: full-width read/write register.
- **TCFG**: bit0 is En, bit1 is Periodic, bits [TVAL_W-1:2] are InitVal. Higher bits read as 0.
- **Reload value**: R = {InitVal, 2'b00}.
- **TVAL**: read-only; returns the countdown value zero-extended. Writes are ignored.
- **TICLR**: write-only. Writing with wdata[0]=1 clears pending. It reads as 0.
- **Internal state**:
  - `tval` [TVAL_W-1:0]: countdown value.
  - `armed`: the timer is counting toward an expiry.
  - `pending`: drives `timer_is`.
- **TCFG write**: sets `tval` <= R and `armed` <= wdata[0].
- **Each cycle with `armed`=1 and no TCFG write**:
  - `tval` ≠ 0: `tval` <= `tval` − 1.
  - `tval` = 0 (expiry): `pending` <= 1. If Periodic, `tval` <= R and `armed` stays 1. Otherwise `tval` holds 0 and `armed` <= 0.
- **En=0**: `tval` is frozen and `armed` = 0.
- **Stable counter**: increments by 1 every cycle and wraps mod 2^64.
- **Read mux**: combinational on `csr_raddr`; unmatched addresses return 0.

## Timing
- **Reset values**: TCFG = 0, `tval` = 0, `armed` = 0, `pending` = 0, TID = CORE_ID, `stable_cnt` = 0. Therefore `timer_is`, `timer_int_req` and `timer_rdata` (non-TID addresses) are all 0.
- **Write visibility**: a write at edge N is visible on reads and outputs after edge N.
- **Expiry latency**: a TCFG write at edge N with En=1 raises `pending` after edge N + R + 1.
- **Periodic interval**: expiries repeat every R + 1 cycles.
- **InitVal = 0**: R = 0. Expiry happens at edge N+1. In periodic mode it then expires every cycle.
- **TCFG write coinciding with an expiry**: the write wins. The expiry is discarded and `pending` is unchanged by it.
- **TICLR clear coinciding with an expiry**: set wins and `pending` stays 1.
- **Reset**: asserting reset mid-count returns all state to reset values immediately (asynchronous). Counting resumes only after a new TCFG write.
- **`timer_int_req`**: follows `crmd_ie` in the same cycle, with no added latency.

## Structure
- CSR addresses `LSOC1K_CSR_TID/TCFG/TVAL/TICLR` and the bit positions `TCFG_EN`, `TCFG_PERIODIC` and `TICLR_CLR` are added to common.vh next to the existing CSR address macros.
- One sub-module: `cpu7_timer_cnt`. It holds `tval`, `armed` and `pending`, and its inputs are the load, clear and config strobes. The top level keeps TID, TCFG, the stable counter, address decode and the read mux.

## Test plan
- **Reset**: reset asserted mid-simulation → all outputs 0, `stable_cnt` = 0; it reads 5 after 5 clocks post-deassert.
- **One-shot**: TCFG = 0x9 (InitVal 2, En, one-shot) at edge N → TVAL reads 8, 7, …, 0. `timer_is` rises after edge N+9 and stays high, and TVAL holds 0.
- **Periodic + clear**: TCFG = 0xB (InitVal 2, En, Periodic) → `pending` sets every 9 cycles. A TICLR write of 1 clears it; a TICLR clear issued in the same cycle as the next expiry leaves `timer_is` = 1.
- **Write vs expiry**: a TCFG write of 0x0 in the expiry cycle → `timer_is` stays 0 and TVAL reads 0 thereafter.
- **Interrupt gating**: `pending` = 1 with `crmd_ie` toggled 0/1/0 → `timer_int_req` = 0/1/0 in the same cycles.
- **Read mux**: TID write 0xDEADBEEF reads back. TVAL write 0x1234 is ignored. TICLR and unmapped addresses read 0. TCFG write 0xFFFFFFFF reads back `{InitVal, Periodic, En}` with bits ≥ TVAL_W zero.

Source files
------------

// File: rtl/cpu7_csr_timer_pkg.sv
// Shared constants for the cpu7 timer CSRs: CSR addresses, TCFG/TICLR bit positions
// and the read-address decode used by the timer read mux.
package cpu7_csr_timer_pkg;

    localparam int GRLEN   = 32;
    localparam int CSR_BIT = 14;

    localparam logic [CSR_BIT-1:0] CSR_TID   = 14'h040;
    localparam logic [CSR_BIT-1:0] CSR_TCFG  = 14'h041;
    localparam logic [CSR_BIT-1:0] CSR_TVAL  = 14'h042;
    localparam logic [CSR_BIT-1:0] CSR_TICLR = 14'h044;

    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;
    localparam int TICLR_CLR     = 0;

    typedef enum logic [1:0] {
        CSR_SEL_NONE = 2'd0,
        CSR_SEL_TID  = 2'd1,
        CSR_SEL_TCFG = 2'd2,
        CSR_SEL_TVAL = 2'd3
    } csr_sel_e;

    // TICLR is write-only, so it decodes to NONE and reads as zero.
    function automatic csr_sel_e csr_read_sel(input logic [CSR_BIT-1:0] addr);
        csr_sel_e sel;
        case (addr)
            CSR_TID:  sel = CSR_SEL_TID;
            CSR_TCFG: sel = CSR_SEL_TCFG;
            CSR_TVAL: sel = CSR_SEL_TVAL;
            default:  sel = CSR_SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cpu7_csr_timer_if.sv
// CSR write/read bus shared between the main CSR block and the timer CSR slice.
interface cpu7_csr_timer_if;
    import cpu7_csr_timer_pkg::*;

    logic [CSR_BIT-1:0] csr_waddr;
    logic [GRLEN-1:0]   csr_wdata;
    logic               csr_wen;
    logic [CSR_BIT-1:0] csr_raddr;
    logic [GRLEN-1:0]   timer_rdata;

    modport master (
        output csr_waddr,
        output csr_wdata,
        output csr_wen,
        output csr_raddr,
        input  timer_rdata
    );

    modport slave (
        input  csr_waddr,
        input  csr_wdata,
        input  csr_wen,
        input  csr_raddr,
        output timer_rdata
    );

endinterface

// File: rtl/cpu7_timer_cnt.sv
// Timer countdown core: holds tval, the armed flag and the pending interrupt bit.
// A load (TCFG write) always beats an expiry in the same cycle; an expiry beats a clear.
module cpu7_timer_cnt #(
    parameter int TVAL_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              load_en,
    input  logic [TVAL_W-1:0] load_val,
    input  logic              periodic,
    input  logic [TVAL_W-1:0] reload_val,
    input  logic              clear,
    output logic [TVAL_W-1:0] tval,
    output logic              pending
);

    logic [TVAL_W-1:0] tval_r;
    logic [TVAL_W-1:0] tval_nxt_s;
    logic              armed_r;
    logic              armed_nxt_s;
    logic              pending_r;
    logic              pending_nxt_s;
    logic              expire_s;

    // Next-state for countdown, arming and pending.
    always_comb begin
        tval_nxt_s    = tval_r;
        armed_nxt_s   = armed_r;
        pending_nxt_s = pending_r;
        expire_s      = 1'b0;

        if (load) begin
            tval_nxt_s  = load_val;
            armed_nxt_s = load_en;
        end else if (armed_r) begin
            if (tval_r != '0) begin
                tval_nxt_s = tval_r - TVAL_W'(1);
            end else begin
                expire_s = 1'b1;
                if (periodic) begin
                    tval_nxt_s = reload_val;
                end else begin
                    armed_nxt_s = 1'b0;
                end
            end
        end else begin
            tval_nxt_s = tval_r;
        end

        if (expire_s) begin
            pending_nxt_s = 1'b1;
        end else if (clear) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tval_r    <= '0;
            armed_r   <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            tval_r    <= tval_nxt_s;
            armed_r   <= armed_nxt_s;
            pending_r <= pending_nxt_s;
        end
    end

    assign tval    = tval_r;
    assign pending = pending_r;

endmodule

// File: rtl/cpu7_csr_timer.sv
// cpu7 timer CSR slice: TID/TCFG/TVAL/TICLR decode, read mux, stable counter and the
// timer interrupt source feeding ESTAT.IS[11].
module cpu7_csr_timer
    import cpu7_csr_timer_pkg::*;
#(
    parameter int TVAL_W  = 32,
    parameter int CORE_ID = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    cpu7_csr_timer_if.slave        bus,
    input  logic                   crmd_ie,
    output logic                   timer_is,
    output logic                   timer_int_req,
    output logic [63:0]            stable_cnt
);

    logic [GRLEN-1:0]  tid_r;
    logic [TVAL_W-1:0] tcfg_r;
    logic [63:0]       stable_cnt_r;

    logic              wr_tid_s;
    logic              wr_tcfg_s;
    logic              wr_ticlr_s;
    logic              clear_s;
    logic [TVAL_W-1:0] load_val_s;
    logic [TVAL_W-1:0] reload_val_s;
    logic [TVAL_W-1:0] tval_s;
    logic              pending_s;
    logic [GRLEN-1:0]  rdata_s;

    assign wr_tid_s   = bus.csr_wen && (bus.csr_waddr == CSR_TID);
    assign wr_tcfg_s  = bus.csr_wen && (bus.csr_waddr == CSR_TCFG);
    assign wr_ticlr_s = bus.csr_wen && (bus.csr_waddr == CSR_TICLR);
    assign clear_s    = wr_ticlr_s && bus.csr_wdata[TICLR_CLR];

    // Reload is InitVal scaled by 4; a load takes it from the incoming write data.
    assign load_val_s   = {bus.csr_wdata[TVAL_W-1:2], 2'b00};
    assign reload_val_s = {tcfg_r[TVAL_W-1:2], 2'b00};

    // TID and TCFG registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tid_r  <= GRLEN'(CORE_ID);
            tcfg_r <= '0;
        end else begin
            if (wr_tid_s) begin
                tid_r <= bus.csr_wdata;
            end else begin
                tid_r <= tid_r;
            end
            if (wr_tcfg_s) begin
                tcfg_r <= bus.csr_wdata[TVAL_W-1:0];
            end else begin
                tcfg_r <= tcfg_r;
            end
        end
    end

    // Free-running stable counter, wraps naturally at 2^64.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_cnt_r <= 64'd0;
        end else begin
            stable_cnt_r <= stable_cnt_r + 64'd1;
        end
    end

    cpu7_timer_cnt #(
        .TVAL_W (TVAL_W)
    ) u_timer_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (wr_tcfg_s),
        .load_en    (bus.csr_wdata[TCFG_EN]),
        .load_val   (load_val_s),
        .periodic   (tcfg_r[TCFG_PERIODIC]),
        .reload_val (reload_val_s),
        .clear      (clear_s),
        .tval       (tval_s),
        .pending    (pending_s)
    );

    // Combinational read mux; TCFG and TVAL are zero-extended to GRLEN.
    always_comb begin
        rdata_s = '0;
        case (csr_read_sel(bus.csr_raddr))
            CSR_SEL_TID:  rdata_s = tid_r;
            CSR_SEL_TCFG: rdata_s[TVAL_W-1:0] = tcfg_r;
            CSR_SEL_TVAL: rdata_s[TVAL_W-1:0] = tval_s;
            default:      rdata_s = '0;
        endcase
    end

    assign bus.timer_rdata = rdata_s;
    assign timer_is        = pending_s;
    assign timer_int_req   = pending_s & crmd_ie;
    assign stable_cnt      = stable_cnt_r;

endmodule

// File: tb/tb_cpu7_csr_timer.sv
// Directed, table-driven bench for cpu7_csr_timer (TVAL_W=16 so TCFG masking is visible).
module tb_cpu7_csr_timer;
    import cpu7_csr_timer_pkg::*;

    logic        clk;
    logic        reset;
    logic        crmd_ie;
    logic        timer_is;
    logic        timer_int_req;
    logic [63:0] stable_cnt;

    int checks;
    int errors;

    cpu7_csr_timer_if bus ();

    cpu7_csr_timer #(
        .TVAL_W  (16),
        .CORE_ID (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .crmd_ie       (crmd_ie),
        .timer_is      (timer_is),
        .timer_int_req (timer_int_req),
        .stable_cnt    (stable_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [13:0] waddr;
        logic [31:0] wdata;
        logic [13:0] raddr;
        logic        ie;
        logic [31:0] exp_rdata;
        logic        exp_is;
        logic        exp_req;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_csr(input logic [13:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.csr_waddr = addr;
        bus.csr_wdata = data;
        bus.csr_wen   = 1'b1;
        @(posedge clk);
        #1;
        bus.csr_wen   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;

        //            wen   waddr      wdata          raddr       ie    exp_rdata      is    req
        vecs[0] = '{1'b1, CSR_TID,   32'hDEADBEEF, CSR_TID,   1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[1] = '{1'b1, CSR_TVAL,  32'h00001234, CSR_TVAL,  1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[2] = '{1'b1, CSR_TICLR, 32'h00000001, CSR_TICLR, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[3] = '{1'b0, CSR_TID,   32'h00000000, 14'h045,   1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, CSR_TID,   32'h00000000, 14'h043,   1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[5] = '{1'b1, CSR_TCFG,  32'hFFFFFFFF, CSR_TCFG,  1'b0, 32'h0000FFFF, 1'b0, 1'b0};
        vecs[6] = '{1'b1, CSR_TVAL,  32'h00001234, CSR_TVAL,  1'b0, 32'h0000FFFB, 1'b0, 1'b0};
        vecs[7] = '{1'b1, CSR_TCFG,  32'h00000000, CSR_TCFG,  1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[8] = '{1'b0, CSR_TID,   32'h00000000, CSR_TVAL,  1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[9] = '{1'b1, CSR_TID,   32'h12345678, CSR_TID,   1'b1, 32'h12345678, 1'b0, 1'b0};

        reset         = 1'b1;
        crmd_ie       = 1'b0;
        bus.csr_wen   = 1'b0;
        bus.csr_waddr = '0;
        bus.csr_wdata = '0;
        bus.csr_raddr = CSR_TID;

        // Power-on reset state.
        step(2);
        check("reset tid", bus.timer_rdata, 64'h3);
        check("reset is", timer_is, 1'b0);
        check("reset req", timer_int_req, 1'b0);
        check("reset stable", stable_cnt, 64'd0);
        bus.csr_raddr = CSR_TCFG;
        #1;
        check("reset tcfg", bus.timer_rdata, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        step(5);
        check("stable after 5", stable_cnt, 64'd5);

        // Read mux / write decode table.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.csr_wen   = vecs[i].wen;
            bus.csr_waddr = vecs[i].waddr;
            bus.csr_wdata = vecs[i].wdata;
            bus.csr_raddr = vecs[i].raddr;
            crmd_ie       = vecs[i].ie;
            @(posedge clk);
            #1;
            bus.csr_wen   = 1'b0;
            check($sformatf("vec%0d rdata", i), bus.timer_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d is", i), timer_is, vecs[i].exp_is);
            check($sformatf("vec%0d req", i), timer_int_req, vecs[i].exp_req);
        end
        crmd_ie = 1'b0;

        // One-shot, InitVal 2 -> R = 8, expiry after edge N+9.
        bus.csr_raddr = CSR_TVAL;
        write_csr(CSR_TCFG, 32'h9);
        check("oneshot tval N", bus.timer_rdata, 64'd8);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check($sformatf("oneshot tval N+%0d", k), bus.timer_rdata, 64'(8 - k));
            check($sformatf("oneshot is N+%0d", k), timer_is, 1'b0);
        end
        step(1);
        check("oneshot is N+9", timer_is, 1'b1);
        check("oneshot tval N+9", bus.timer_rdata, 64'd0);
        step(3);
        check("oneshot is held", timer_is, 1'b1);
        check("oneshot tval held", bus.timer_rdata, 64'd0);
        check("oneshot req ie0", timer_int_req, 1'b0);

        // Periodic, R = 8: expiries at N+9, N+18, N+27.
        write_csr(CSR_TICLR, 32'h1);
        check("ticlr clears", timer_is, 1'b0);
        write_csr(CSR_TCFG, 32'hB);
        step(8);
        check("per is N+8", timer_is, 1'b0);
        step(1);
        check("per is N+9", timer_is, 1'b1);
        check("per reload N+9", bus.timer_rdata, 64'd8);
        write_csr(CSR_TICLR, 32'h1);
        check("per clear N+10", timer_is, 1'b0);
        check("per tval N+10", bus.timer_rdata, 64'd7);
        step(7);
        check("per is N+17", timer_is, 1'b0);
        step(1);
        check("per is N+18", timer_is, 1'b1);
        write_csr(CSR_TICLR, 32'h1);
        check("per clear N+19", timer_is, 1'b0);
        step(7);
        check("per is N+26", timer_is, 1'b0);
        write_csr(CSR_TICLR, 32'h1);
        check("clear vs expiry", timer_is, 1'b1);

        // TCFG write in the expiry cycle (N+36) discards the expiry.
        write_csr(CSR_TICLR, 32'h1);
        check("pre-race clear", timer_is, 1'b0);
        step(7);
        check("pre-race tval", bus.timer_rdata, 64'd0);
        check("pre-race is", timer_is, 1'b0);
        write_csr(CSR_TCFG, 32'h0);
        check("write vs expiry is", timer_is, 1'b0);
        check("write vs expiry tval", bus.timer_rdata, 64'd0);
        step(3);
        check("after race is", timer_is, 1'b0);
        check("after race tval", bus.timer_rdata, 64'd0);

        // InitVal 0 one-shot: expiry at N+1, then interrupt gating.
        write_csr(CSR_TCFG, 32'h1);
        check("iv0 is N", timer_is, 1'b0);
        step(1);
        check("iv0 is N+1", timer_is, 1'b1);
        crmd_ie = 1'b0;
        #1;
        check("gate ie0", timer_int_req, 1'b0);
        crmd_ie = 1'b1;
        #1;
        check("gate ie1", timer_int_req, 1'b1);
        crmd_ie = 1'b0;
        #1;
        check("gate ie0 again", timer_int_req, 1'b0);
        write_csr(CSR_TICLR, 32'h1);
        step(2);
        check("iv0 oneshot disarmed", timer_is, 1'b0);

        // InitVal 0 periodic expires every cycle, so a clear never wins.
        write_csr(CSR_TCFG, 32'h3);
        step(1);
        check("iv0 per is", timer_is, 1'b1);
        write_csr(CSR_TICLR, 32'h1);
        check("iv0 per clear loses", timer_is, 1'b1);

        // Asynchronous reset mid-count.
        write_csr(CSR_TCFG, 32'hB);
        step(3);
        crmd_ie = 1'b1;
        reset   = 1'b1;
        #2;
        check("mid reset is", timer_is, 1'b0);
        check("mid reset req", timer_int_req, 1'b0);
        check("mid reset stable", stable_cnt, 64'd0);
        check("mid reset tval", bus.timer_rdata, 64'd0);
        bus.csr_raddr = CSR_TID;
        #1;
        check("mid reset tid", bus.timer_rdata, 64'h3);
        @(negedge clk);
        reset = 1'b0;
        bus.csr_raddr = CSR_TVAL;
        step(5);
        check("post reset stable", stable_cnt, 64'd5);
        check("post reset tval", bus.timer_rdata, 64'd0);
        check("post reset is", timer_is, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
